// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: register-addressed command sequencer driving a 32-bit combinational ALU
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_op/cmd_rd/cmd_rs1/cmd_rs2 carry the command
//   wr_en/wr_addr/wr_data       register preload, honoured in every state, address 0 ignored
//   alu_a/alu_b/alu_op          registered operands/opcode, change only on the accept edge
//   alu_out                     combinational ALU result, captured after ALU_LAT cycles
//   rsp_valid/rsp_ready         response handshake; rsp_data/rsp_rd/rsp_zero carry the result
//   busy                        sequencer not idle
//
// Timing: EXEC lasts ALU_LAT cycles, so rsp_valid is high after the ALU_LAT-th edge that
// follows the accept edge (ALU_LAT+1 edges counting the accept edge itself).
module alu_cmd_sequencer #(
  parameter int AW      = 3,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [5:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [5:0]    alu_op,
  input  logic [31:0]   alu_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [AW-1:0] rsp_rd,
  output logic          rsp_zero,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);
  state_t        state, state_nx;
  logic [31:0]   rf [2**AW];
  logic [3:0]    cnt;
  logic [AW-1:0] rd_q;
  logic          accept, capture;
  logic [31:0]   opa, opb;
  assign accept  = cmd_valid & cmd_ready;
  assign capture = (state == EXEC) && (cnt == '0);
  // A preload landing on the accept edge is forwarded into the operand; R0 is never written so stays 0.
  assign opa = (wr_en && wr_addr == cmd_rs1 && cmd_rs1 != '0) ? wr_data : rf[cmd_rs1];
  assign opb = (wr_en && wr_addr == cmd_rs2 && cmd_rs2 != '0) ? wr_data : rf[cmd_rs2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx  = state;
    cmd_ready = (state == IDLE) && rst_n;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    if (state == IDLE && accept) state_nx = EXEC;
    else if (capture) state_nx = RESP;
    else if (state == RESP && rsp_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_rd   <= '0;
      rsp_zero <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= opa;
        alu_b  <= opb;
        alu_op <= cmd_op;
        rd_q   <= cmd_rd;
        cnt    <= LAT_M1;
      end else if (state == EXEC && cnt != '0) cnt <= cnt - 4'd1;
      if (capture) begin
        rsp_data <= alu_out;
        rsp_rd   <= rd_q;
        rsp_zero <= (alu_out == '0);
      end
    end
  // Writeback has priority over a preload to the same register on the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 2**AW; i++) rf[i] <= '0;
    else for (int i = 1; i < 2**AW; i++)
      if (capture && rd_q == AW'(i)) rf[i] <= alu_out;
      else if (wr_en && wr_addr == AW'(i)) rf[i] <= wr_data;
endmodule
